// File: rtl/vjtag_dr_bridge.sv
// Virtual JTAG data-register consumer: oversamples the tap in the clk domain. It shifts a DW-bit DR
// LSB-first and hands command frames to the fabric over a single-entry valid/ready buffer.
module vjtag_dr_bridge #(
   parameter int DW       = 8,
   parameter int SYNC_LEN = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tck,
   input  logic          tdi,
   input  logic          ir_in,
   input  logic          virtual_state_cdr,
   input  logic          virtual_state_sdr,
   input  logic          virtual_state_udr,
   output logic          tdo,
   output logic [DW-1:0] cmd_data,
   output logic          cmd_valid,
   input  logic          cmd_ready,
   input  logic [DW-3:0] rsp_data,
   output logic          overrun
);

   // Handshake: cmd_data is stable while cmd_valid=1; the command transfers on a clk edge with
   // cmd_valid & cmd_ready, and cmd_valid drops on the following clk.

   localparam int BW = 6;

   logic [SYNC_LEN-1:0][BW-1:0] sync_q, sync_d;
   logic                        tck_d_q, tck_d_d;
   logic [DW-1:0]               shift_q, shift_d;
   logic [DW-1:0]               cmd_data_q, cmd_data_d;
   logic                        cmd_valid_q, cmd_valid_d;
   logic                        overrun_q, overrun_d;
   logic                        tdo_q, tdo_d;

   logic tck_s, tdi_s, ir_s, cdr_s, sdr_s, udr_s;
   logic tck_rise, tck_fall, accept, drop, clear;

   // All tap inputs travel through one chain so they stay aligned with tck.
   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = {tck, tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr};
      for (int i = 1; i < SYNC_LEN; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign {tck_s, tdi_s, ir_s, cdr_s, sdr_s, udr_s} = sync_q[SYNC_LEN-1];
   assign tck_rise = tck_s & ~tck_d_q;
   assign tck_fall = ~tck_s & tck_d_q;
   assign tck_d_d  = tck_s;
   assign accept   = cmd_valid_q & cmd_ready;

   always_comb begin
      shift_d     = shift_q;
      cmd_data_d  = cmd_data_q;
      cmd_valid_d = cmd_valid_q;
      overrun_d   = overrun_q;
      tdo_d       = tdo_q;
      drop        = 1'b0;
      clear       = 1'b0;

      if (accept) begin
         cmd_valid_d = 1'b0;
      end

      if (tck_rise) begin
         if (cdr_s) begin
            if (ir_s) begin
               shift_d = cmd_data_q;
            end else begin
               shift_d = {cmd_valid_q, overrun_q, rsp_data};
               clear   = 1'b1;
            end
         end else if (sdr_s) begin
            shift_d = {tdi_s, shift_q[DW-1:1]};
         end else if (udr_s && ir_s) begin
            // A pending entry (even one being accepted this clk) means the new frame is lost.
            if (cmd_valid_q) begin
               drop = 1'b1;
            end else begin
               cmd_data_d  = shift_q;
               cmd_valid_d = 1'b1;
            end
         end
      end

      if (clear) begin
         overrun_d = 1'b0;
      end
      if (drop) begin
         overrun_d = 1'b1;
      end

      if (tck_fall) begin
         tdo_d = shift_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= '0;
         tck_d_q     <= 1'b0;
         shift_q     <= '0;
         cmd_data_q  <= '0;
         cmd_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         tdo_q       <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         tck_d_q     <= tck_d_d;
         shift_q     <= shift_d;
         cmd_data_q  <= cmd_data_d;
         cmd_valid_q <= cmd_valid_d;
         overrun_q   <= overrun_d;
         tdo_q       <= tdo_d;
      end
   end

   assign tdo       = tdo_q;
   assign cmd_data  = cmd_data_q;
   assign cmd_valid = cmd_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_vjtag_dr_bridge.sv
// Bench for vjtag_dr_bridge: drives tck at clk/8 and compares tdo and the command buffer against
// a frame-level model of the data register.
module tb_vjtag_dr_bridge;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tck = 1'b0;
   logic          tdi = 1'b0;
   logic          ir_in = 1'b0;
   logic          cdr = 1'b0, sdr = 1'b0, udr = 1'b0;
   logic          tdo;
   logic [DW-1:0] cmd_data;
   logic          cmd_valid;
   logic          cmd_ready = 1'b0;
   logic [DW-3:0] rsp_data = '0;
   logic          overrun;

   int total = 0;
   int bad   = 0;

   // model of the data register and the command buffer
   logic [DW-1:0] m_sr, m_data;
   logic          m_valid, m_ovr, m_tdo;

   always #5 clk = ~clk;

   vjtag_dr_bridge #(.DW(DW), .SYNC_LEN(2)) dut (
      .clk(clk), .rst(rst), .tck(tck), .tdi(tdi), .ir_in(ir_in),
      .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
      .tdo(tdo), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .overrun(overrun)
   );

   task automatic model_reset();
      m_sr = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_tdo = 1'b0;
   endtask

   // One tck period with the given tap state; rdy pulses cmd_ready on the clk that acts on the rise.
   task automatic tck_pulse(input bit c, input bit s, input bit u, input bit d, input bit rdy,
                            output bit tdo_seen);
      logic [DW+1:0] pre, post;
      cdr = c; sdr = s; udr = u; tdi = d;
      repeat (4) @(negedge clk);
      tdo_seen = tdo;
      total++;
      if (tdo !== m_tdo) begin
         bad++;
         $display("FAIL tdo_before_rise: got %0b want %0b", tdo, m_tdo);
      end
      pre = {m_valid, m_ovr, m_data};
      if (c) begin
         if (ir_in) m_sr = m_data;
         else begin
            m_sr  = {m_valid, m_ovr, rsp_data};
            m_ovr = 1'b0;
         end
      end else if (s) begin
         m_sr = (m_sr >> 1) | (DW'(d) << (DW-1));
      end else if (u && ir_in) begin
         if (m_valid) m_ovr = 1'b1;
         else begin
            m_data  = m_sr;
            m_valid = 1'b1;
         end
      end
      if (rdy && pre[DW+1]) m_valid = 1'b0;
      post = {m_valid, m_ovr, m_data};
      tck = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({cmd_valid, overrun, cmd_data} !== pre) begin
         bad++;
         $display("FAIL outputs_before_action: got %h want %h", {cmd_valid, overrun, cmd_data}, pre);
      end
      if (rdy) cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      @(negedge clk);
      total++;
      if ({cmd_valid, overrun, cmd_data} !== post) begin
         bad++;
         $display("FAIL outputs_after_action: got %h want %h", {cmd_valid, overrun, cmd_data}, post);
      end
      tck = 1'b0;
      m_tdo = m_sr[0];
   endtask

   // Capture, n shift bits of d, update, then one idle tck so the last fall's tdo is checked.
   task automatic scan_dr(input bit ir_v, input int n, input logic [15:0] d, input bit rdy_upd,
                          output logic [DW-1:0] outb);
      bit t;
      ir_in = ir_v;
      outb = '0;
      tck_pulse(1, 0, 0, 0, 0, t);
      for (int k = 0; k < n; k++) begin
         tck_pulse(0, 1, 0, d[k%16], 0, t);
         if (k < DW) outb[k] = t;
      end
      tck_pulse(0, 0, 1, 0, rdy_upd, t);
      tck_pulse(0, 0, 0, 0, 0, t);
   endtask

   task automatic accept_cmd();
      @(negedge clk);
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      if (m_valid) m_valid = 1'b0;
      total++;
      if (cmd_valid !== 1'b0) begin
         bad++;
         $display("FAIL accept_clears_valid: got %0b want 0", cmd_valid);
      end
   endtask

   task automatic check_buf(input string name, input logic v, input logic o, input logic [DW-1:0] d);
      total++;
      if ({cmd_valid, overrun, cmd_data} !== {v, o, d}) begin
         bad++;
         $display("FAIL %s: got v=%0b o=%0b d=%h want v=%0b o=%0b d=%h",
                  name, cmd_valid, overrun, cmd_data, v, o, d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tck = $urandom_range(0, 1); tdi = $urandom_range(0, 1);
         cdr = $urandom_range(0, 1); sdr = $urandom_range(0, 1); udr = $urandom_range(0, 1);
         ir_in = $urandom_range(0, 1);
      end
      tck = 1'b0; cdr = 1'b0; sdr = 1'b0; udr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      total++;
      if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo: got %0b want 0", tdo); end
      total++;
      if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", cmd_valid); end
      total++;
      if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
      total++;
      if (cmd_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", cmd_data); end
   endtask

   task automatic test_write();
      logic [DW-1:0] o;
      scan_dr(1, 8, 16'h00A5, 0, o);
      check_buf("write_a5", 1'b1, 1'b0, 8'hA5);
      accept_cmd();
   endtask

   task automatic test_read();
      logic [DW-1:0] o;
      rsp_data = 6'h2C;
      scan_dr(0, 8, 16'h0000, 0, o);
      total++;
      if (o !== 8'h2C) begin bad++; $display("FAIL read_tdo_seq: got %h want 2c", o); end
   endtask

   task automatic test_overrun();
      logic [DW-1:0] o;
      scan_dr(1, 8, 16'h0011, 0, o);
      scan_dr(1, 8, 16'h0022, 0, o);
      check_buf("overrun_drop", 1'b1, 1'b1, 8'h11);
      scan_dr(0, 8, 16'h0000, 0, o);
      total++;
      if (o[6] !== 1'b1) begin bad++; $display("FAIL overrun_capture_bit6: got %0b want 1", o[6]); end
      check_buf("overrun_cleared", 1'b1, 1'b0, 8'h11);
      accept_cmd();
   endtask

   task automatic test_collision();
      logic [DW-1:0] o;
      scan_dr(1, 8, 16'h005A, 0, o);
      scan_dr(1, 8, 16'h0099, 1, o);
      check_buf("collision", 1'b0, 1'b1, 8'h5A);
   endtask

   task automatic test_reset_mid_scan();
      bit t;
      logic [DW-1:0] o;
      ir_in = 1'b1;
      tck_pulse(1, 0, 0, 0, 0, t);
      for (int k = 0; k < 4; k++) tck_pulse(0, 1, 0, 1, 0, t);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_buf("mid_scan_reset", 1'b0, 1'b0, 8'h00);
      scan_dr(1, 8, 16'h003C, 0, o);
      check_buf("after_reset_write", 1'b1, 1'b0, 8'h3C);
      accept_cmd();
   endtask

   task automatic test_random();
      logic [DW-1:0] o;
      for (int i = 0; i < 20; i++) begin
         rsp_data = 6'($urandom);
         scan_dr($urandom_range(0, 1), $urandom_range(1, 12), 16'($urandom), $urandom_range(0, 1), o);
         if ($urandom_range(0, 1) == 1) accept_cmd();
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write();
      test_read();
      test_overrun();
      test_collision();
      test_reset_mid_scan();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
